// File: rtl/morse_pkg.sv
// Shared constants, payload types and FSM state encoding for the Morse beacon.
package morse_pkg;

  // Symbol codes held in the message buffer
  localparam logic [5:0] CODE_A      = 6'd0;
  localparam logic [5:0] CODE_Z      = 6'd25;
  localparam logic [5:0] CODE_DIGIT0 = 6'd26;
  localparam logic [5:0] CODE_DIGIT9 = 6'd35;
  localparam logic [5:0] SPACE_CODE  = 6'd63;

  // Span lengths in units
  localparam logic [2:0] DOT        = 3'd1;
  localparam logic [2:0] DASH       = 3'd3;
  localparam logic [2:0] ELEM_GAP   = 3'd1;
  localparam logic [2:0] CHAR_GAP   = 3'd3;
  localparam logic [2:0] WORD_EXTRA = 3'd4;

  // Element pattern of one symbol: bit i of dash_mask set means element i is a dash
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] dash_mask;
  } morse_pat_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_MARK     = 3'd2,
    S_ELEM_GAP = 3'd3,
    S_CHAR_GAP = 3'd4,
    S_WORD_GAP = 3'd5,
    S_REP_GAP  = 3'd6
  } state_t;

endpackage

// File: rtl/morse_lut.sv
// Combinational symbol-code to ITU Morse element pattern lookup.
module morse_lut
  import morse_pkg::*;
(
  input  logic [5:0] code,
  output morse_pat_t pat
);

  // Codes outside A-Z / 0-9 decode as a zero-length (word space) pattern
  always_comb begin
    pat = '0;
    case (code)
      6'd0:  pat = {3'd2, 5'b00010}; // A .-
      6'd1:  pat = {3'd4, 5'b00001}; // B -...
      6'd2:  pat = {3'd4, 5'b00101}; // C -.-.
      6'd3:  pat = {3'd3, 5'b00001}; // D -..
      6'd4:  pat = {3'd1, 5'b00000}; // E .
      6'd5:  pat = {3'd4, 5'b00100}; // F ..-.
      6'd6:  pat = {3'd3, 5'b00011}; // G --.
      6'd7:  pat = {3'd4, 5'b00000}; // H ....
      6'd8:  pat = {3'd2, 5'b00000}; // I ..
      6'd9:  pat = {3'd4, 5'b01110}; // J .---
      6'd10: pat = {3'd3, 5'b00101}; // K -.-
      6'd11: pat = {3'd4, 5'b00010}; // L .-..
      6'd12: pat = {3'd2, 5'b00011}; // M --
      6'd13: pat = {3'd2, 5'b00001}; // N -.
      6'd14: pat = {3'd3, 5'b00111}; // O ---
      6'd15: pat = {3'd4, 5'b00110}; // P .--.
      6'd16: pat = {3'd4, 5'b01011}; // Q --.-
      6'd17: pat = {3'd3, 5'b00010}; // R .-.
      6'd18: pat = {3'd3, 5'b00000}; // S ...
      6'd19: pat = {3'd1, 5'b00001}; // T -
      6'd20: pat = {3'd3, 5'b00100}; // U ..-
      6'd21: pat = {3'd4, 5'b01000}; // V ...-
      6'd22: pat = {3'd3, 5'b00110}; // W .--
      6'd23: pat = {3'd4, 5'b01001}; // X -..-
      6'd24: pat = {3'd4, 5'b01101}; // Y -.--
      6'd25: pat = {3'd4, 5'b00011}; // Z --..
      6'd26: pat = {3'd5, 5'b11111}; // 0 -----
      6'd27: pat = {3'd5, 5'b11110}; // 1 .----
      6'd28: pat = {3'd5, 5'b11100}; // 2 ..---
      6'd29: pat = {3'd5, 5'b11000}; // 3 ...--
      6'd30: pat = {3'd5, 5'b10000}; // 4 ....-
      6'd31: pat = {3'd5, 5'b00000}; // 5 .....
      6'd32: pat = {3'd5, 5'b00001}; // 6 -....
      6'd33: pat = {3'd5, 5'b00011}; // 7 --...
      6'd34: pat = {3'd5, 5'b00111}; // 8 ---..
      6'd35: pat = {3'd5, 5'b01111}; // 9 ----.
      default: pat = '0;
    endcase
  end

endmodule

// File: rtl/morse_beacon.sv
// Morse beacon: keys a buffered symbol message at a programmable unit rate.
module morse_beacon
  import morse_pkg::*;
#(
  parameter int unsigned MAX_CHARS = 16,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             repeat_en,
  input  logic [DIV_W-1:0]                 dot_div,
  input  logic [$clog2(MAX_CHARS+1)-1:0]   msg_len,
  input  logic                             wr_en,
  input  logic [$clog2(MAX_CHARS)-1:0]     wr_addr,
  input  logic [5:0]                       wr_data,
  output logic                             key_out,
  output logic                             busy,
  output logic                             msg_done
);

  localparam int unsigned LEN_W = $clog2(MAX_CHARS + 1);
  localparam int unsigned IDX_W = $clog2(MAX_CHARS);

  state_t           state, state_next, fetch_state;
  logic [5:0]       buffer [MAX_CHARS];
  logic [DIV_W-1:0] unit_q, pre;
  logic [2:0]       units, elem, elem_nx;
  logic [IDX_W-1:0] idx, fetch_idx;
  logic [LEN_W-1:0] len_q;
  morse_pat_t       pat, fpat;
  logic             unit_end, span_end, last_sym, from_gap;
  logic             new_span, fetch, elem_inc, pass_end;
  logic [2:0]       span_units, fetch_units;

  assign unit_end = (pre == unit_q - DIV_W'(1));
  assign span_end = unit_end && (units == 3'd1);
  assign last_sym = (LEN_W'(idx) == len_q - LEN_W'(1));
  assign from_gap = (state == S_CHAR_GAP) || (state == S_WORD_GAP);
  assign elem_nx  = elem + 3'd1;

  // Next symbol comes from idx+1 at a gap end; LOAD and REP_GAP exit use idx (0)
  assign fetch_idx = from_gap ? idx + IDX_W'(1) : idx;

  morse_lut u_lut (
    .code (buffer[fetch_idx]),
    .pat  (fpat)
  );

  assign fetch_state = (fpat.len == 3'd0) ? S_WORD_GAP : S_MARK;
  assign fetch_units = (fpat.len == 3'd0) ? WORD_EXTRA : (fpat.dash_mask[0] ? DASH : DOT);

  // Symbol buffer write port, not reset
  always_ff @(posedge clk) begin
    if (wr_en) buffer[wr_addr] <= wr_data;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and span control; symbols after the first are fetched inline at
  // gap end so back-to-back spans carry no extra cycle
  always_comb begin
    state_next = state;
    new_span   = 1'b0;
    span_units = 3'd0;
    fetch      = 1'b0;
    elem_inc   = 1'b0;
    pass_end   = 1'b0;
    if (state != S_IDLE && stop) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !stop && msg_len != '0) state_next = S_LOAD;
        end
        S_LOAD, S_REP_GAP: begin
          if (state == S_LOAD || span_end) begin
            fetch      = 1'b1;
            new_span   = 1'b1;
            state_next = fetch_state;
            span_units = fetch_units;
          end
        end
        S_MARK: begin
          if (span_end) begin
            new_span = 1'b1;
            if (elem_nx < pat.len) begin
              state_next = S_ELEM_GAP;
              span_units = ELEM_GAP;
            end else begin
              state_next = S_CHAR_GAP;
              span_units = CHAR_GAP;
            end
          end
        end
        S_ELEM_GAP: begin
          if (span_end) begin
            new_span   = 1'b1;
            elem_inc   = 1'b1;
            state_next = S_MARK;
            span_units = pat.dash_mask[elem_nx] ? DASH : DOT;
          end
        end
        S_CHAR_GAP, S_WORD_GAP: begin
          if (span_end) begin
            if (last_sym) begin
              pass_end = 1'b1;
              if (repeat_en) begin
                state_next = S_REP_GAP;
                new_span   = 1'b1;
                span_units = WORD_EXTRA;
              end else begin
                state_next = S_IDLE;
              end
            end else begin
              fetch      = 1'b1;
              new_span   = 1'b1;
              state_next = fetch_state;
              span_units = fetch_units;
            end
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Latch unit length and clamped message length at start acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      unit_q <= DIV_W'(1);
      len_q  <= '0;
    end else if (state == S_IDLE && state_next == S_LOAD) begin
      unit_q <= (dot_div == '0) ? DIV_W'(1) : dot_div;
      len_q  <= (msg_len > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : msg_len;
    end
  end

  // Unit prescaler: counts clk cycles within one unit
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE || state_next == S_IDLE || new_span || unit_end) pre <= '0;
    else                                                                      pre <= pre + DIV_W'(1);
  end

  // Unit counter: units remaining in the current span
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE || state_next == S_IDLE) units <= '0;
    else if (new_span)                                  units <= span_units;
    else if (unit_end)                                  units <= units - 3'd1;
  end

  // Element counter within the latched symbol pattern
  always_ff @(posedge clk) begin
    if (rst || fetch) elem <= '0;
    else if (elem_inc) elem <= elem_nx;
  end

  // Latched pattern of the symbol being sent, immune to later buffer writes
  always_ff @(posedge clk) begin
    if (rst)        pat <= '0;
    else if (fetch) pat <= fpat;
  end

  // Symbol index; rewinds at pass end and on return to idle
  always_ff @(posedge clk) begin
    if (rst || state_next == S_IDLE || pass_end) idx <= '0;
    else if (fetch && from_gap)                 idx <= idx + IDX_W'(1);
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      key_out  <= 1'b0;
      busy     <= 1'b0;
      msg_done <= 1'b0;
    end else begin
      key_out  <= (state == S_MARK) && !stop;
      busy     <= (state_next != S_IDLE);
      msg_done <= pass_end;
    end
  end

endmodule
